// File: rtl/btn_pkg.sv
// Shared definitions for the push-button event front-end: event codes and the
// record that travels from the arbiter through the event FIFO.
package btn_pkg;

   localparam int EVT_CODE_W = 2;
   localparam int EVT_ID_W   = 3;
   localparam int EVT_W      = EVT_ID_W + EVT_CODE_W;

   typedef enum logic [EVT_CODE_W-1:0] {
      EVT_PRESS   = 2'd0,
      EVT_RELEASE = 2'd1,
      EVT_LONG    = 2'd2,
      EVT_REPEAT  = 2'd3
   } evt_code_e;

   typedef struct packed {
      logic [EVT_ID_W-1:0] id;
      evt_code_e           code;
   } evt_t;

endpackage

// File: rtl/button_event_ctrl_if.sv
// Valid/ready event stream from the button controller to its consumer.
interface button_event_ctrl_if;

   logic                           evt_valid;
   logic                           evt_ready;
   logic [btn_pkg::EVT_CODE_W-1:0] evt_code;
   logic [btn_pkg::EVT_ID_W-1:0]   evt_id;

   modport master (output evt_valid, output evt_code, output evt_id, input  evt_ready);
   modport slave  (input  evt_valid, input  evt_code, input  evt_id, output evt_ready);

endinterface

// File: rtl/btn_channel.sv
// One button: 2-flop sync, tick-based debounce, hold/repeat timing and a
// one-deep pending event register that the top-level arbiter drains.
module btn_channel
   import btn_pkg::*;
#(
   parameter int DEB_TICKS  = 8,
   parameter int LONG_TICKS = 500,
   parameter int REP_TICKS  = 100
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      btn_n,
   input  logic      tick,
   input  logic      grant,
   output logic      btn_state,
   output logic      pend_valid,
   output evt_code_e pend_code,
   output logic      ovf_set
);

   localparam int DEB_W  = $clog2(DEB_TICKS);
   localparam int HOLD_W = $clog2(LONG_TICKS + 1);
   localparam int REP_W  = $clog2(REP_TICKS + 1);

   logic              sync1_q, sync2_q;
   logic              state_q, state_d;
   logic [DEB_W-1:0]  deb_q, deb_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [REP_W-1:0]  rep_q, rep_d;
   logic              long_done_q, long_done_d;
   logic              pend_valid_q, pend_valid_d;
   evt_code_e         pend_code_q, pend_code_d;
   logic              raise, occupied;
   evt_code_e         raise_code;

   always_comb begin
      // NOTE: every _d starts from its _q so no path through this block infers a latch.
      state_d     = state_q;
      deb_d       = deb_q;
      hold_d      = hold_q;
      rep_d       = rep_q;
      long_done_d = long_done_q;
      raise       = 1'b0;
      raise_code  = EVT_PRESS;

      if (sync2_q == state_q) begin
         deb_d = '0;
      end else if (tick) begin
         if (deb_q == DEB_W'(DEB_TICKS - 1)) begin
            state_d     = ~state_q;
            deb_d       = '0;
            hold_d      = '0;
            rep_d       = '0;
            long_done_d = 1'b0;
            raise       = 1'b1;
            if (state_q) raise_code = EVT_RELEASE;
            else         raise_code = EVT_PRESS;
         end else begin
            deb_d = deb_q + 1'b1;
         end
      end

      // Hold timing; a release on the same tick wins and resets the phase.
      if (!raise && state_q && tick) begin
         if (!long_done_q) begin
            hold_d = hold_q + 1'b1;
            if (hold_d == HOLD_W'(LONG_TICKS)) begin
               raise       = 1'b1;
               raise_code  = EVT_LONG;
               long_done_d = 1'b1;
            end
         end else begin
            rep_d = rep_q + 1'b1;
            if (rep_d == REP_W'(REP_TICKS)) begin
               raise      = 1'b1;
               raise_code = EVT_REPEAT;
               rep_d      = '0;
            end
         end
      end

      // A slot granted this cycle is free for a new event on the same edge.
      occupied     = pend_valid_q & ~grant;
      pend_valid_d = occupied;
      pend_code_d  = pend_code_q;
      ovf_set      = 1'b0;
      if (raise) begin
         if (!occupied) begin
            pend_valid_d = 1'b1;
            pend_code_d  = raise_code;
         end else begin
            ovf_set = 1'b1;
            // A release replaces whatever is stuck so the consumer ends on the true level.
            if (raise_code == EVT_RELEASE) pend_code_d = EVT_RELEASE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         state_q      <= 1'b0;
         deb_q        <= '0;
         hold_q       <= '0;
         rep_q        <= '0;
         long_done_q  <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_code_q  <= EVT_PRESS;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
         sync1_q      <= ~btn_n;
         sync2_q      <= sync1_q;
         state_q      <= state_d;
         deb_q        <= deb_d;
         hold_q       <= hold_d;
         rep_q        <= rep_d;
         long_done_q  <= long_done_d;
         pend_valid_q <= pend_valid_d;
         pend_code_q  <= pend_code_d;
      end
   end

   assign btn_state  = state_q;
   assign pend_valid = pend_valid_q;
   assign pend_code  = pend_code_q;

endmodule

// File: rtl/button_event_ctrl.sv
// Multi-button front-end: shared ms prescaler, per-button channels, round-robin
// arbiter and a small event FIFO drained over a valid/ready stream.
module button_event_ctrl
   import btn_pkg::*;
#(
   parameter int N_BTN      = 4,
   parameter int TICK_DIV   = 50000,
   parameter int DEB_TICKS  = 8,
   parameter int LONG_TICKS = 500,
   parameter int REP_TICKS  = 100,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_BTN-1:0]    btn_n,
   output logic [N_BTN-1:0]    btn_state,
   button_event_ctrl_if.master evt,
   output logic                evt_overflow,
   input  logic                clr_overflow
);

   localparam int TICK_W = $clog2(TICK_DIV);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int IDX_W  = (N_BTN > 1) ? $clog2(N_BTN) : 1;

   logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
   logic              tick;
   logic [N_BTN-1:0]  pend_valid, grant_vec, ovf_set;
   evt_code_e         pend_code [N_BTN];
   logic [IDX_W-1:0]  last_q, last_d, grant_idx, cand_idx;
   logic              grant_any, can_push, pop, full;
   evt_t              push_rec;
   evt_t              mem_q [FIFO_DEPTH];
   evt_t              mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    count_q, count_d;
   logic              ovf_q, ovf_d;

   assign tick       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
   assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      btn_channel #(
         .DEB_TICKS (DEB_TICKS),
         .LONG_TICKS(LONG_TICKS),
         .REP_TICKS (REP_TICKS)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .btn_n     (btn_n[i]),
         .tick      (tick),
         .grant     (grant_vec[i]),
         .btn_state (btn_state[i]),
         .pend_valid(pend_valid[i]),
         .pend_code (pend_code[i]),
         .ovf_set   (ovf_set[i])
      );
   end

   assign full     = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
   assign pop      = evt.evt_valid & evt.evt_ready;
   assign can_push = ~full | pop;

   // Round-robin: search starts one past the most recently granted channel.
   always_comb begin
      grant_vec = '0;
      grant_any = 1'b0;
      grant_idx = last_q;
      cand_idx  = '0;
      last_d    = last_q;
      for (int k = 1; k <= N_BTN; k++) begin
         cand_idx = IDX_W'((int'(last_q) + k) % N_BTN);
         if (!grant_any && can_push && pend_valid[cand_idx]) begin
            grant_any = 1'b1;
            grant_idx = cand_idx;
         end
      end
      if (grant_any) begin
         grant_vec[grant_idx] = 1'b1;
         last_d               = grant_idx;
      end
      push_rec = '{id: EVT_ID_W'(grant_idx), code: pend_code[grant_idx]};
   end

   always_comb begin
      mem_d = mem_q;
      if (grant_any) mem_d[wr_ptr_q] = push_rec;
      wr_ptr_d = grant_any ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q + {{PTR_W{1'b0}}, grant_any} - {{PTR_W{1'b0}}, pop};
      ovf_d    = clr_overflow ? 1'b0 : ovf_q;
      if (|ovf_set) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt_q <= '0;
         last_q     <= IDX_W'(N_BTN - 1);
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         // NOTE: storage is reset because the head entry drives evt_code/evt_id directly.
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
         last_q     <= last_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         mem_q      <= mem_d;
      end
   end

   assign evt.evt_valid = (count_q != '0);
   assign evt.evt_code  = mem_q[rd_ptr_q].code;
   assign evt.evt_id    = mem_q[rd_ptr_q].id;
   assign evt_overflow  = ovf_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Scoreboard bench for button_event_ctrl: stimulus queues expected events, a
// negedge monitor pops and compares every accepted head event.
module tb_button_event_ctrl;
   import btn_pkg::*;

   localparam int N_BTN      = 4;
   localparam int TICK_DIV   = 4;
   localparam int DEB_TICKS  = 3;
   localparam int LONG_TICKS = 10;
   localparam int REP_TICKS  = 5;
   localparam int FIFO_DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [N_BTN-1:0] btn_n;
   logic [N_BTN-1:0] btn_state;
   logic             evt_overflow;
   logic             clr_overflow;

   int   checks     = 0;
   int   errors     = 0;
   int   cyc        = 0;
   int   model_last = N_BTN - 1;
   evt_t exp_q [$];
   evt_t mon_e;
   int   press_cyc [8];
   int   rep_cyc   [8];

   button_event_ctrl_if evt_if ();

   button_event_ctrl #(
      .N_BTN     (N_BTN),
      .TICK_DIV  (TICK_DIV),
      .DEB_TICKS (DEB_TICKS),
      .LONG_TICKS(LONG_TICKS),
      .REP_TICKS (REP_TICKS),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_n       (btn_n),
      .btn_state   (btn_state),
      .evt         (evt_if),
      .evt_overflow(evt_overflow),
      .clr_overflow(clr_overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic void expect_evt(input int id, input evt_code_e code);
      exp_q.push_back('{id: 3'(id), code: code});
      model_last = id;
   endfunction

   function automatic void expect_rr(input evt_code_e code);
      int start = model_last;
      for (int k = 1; k <= N_BTN; k++) expect_evt((start + k) % N_BTN, code);
   endfunction

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_state(input int idx, input logic val, input int budget, input string name);
      int n = 0;
      while (btn_state[idx] !== val && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(btn_state[idx]), 32'(val));
   endtask

   task automatic drain(input int budget, input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   // Monitor: every accepted head event must match the next expected entry.
   always @(negedge clk) begin
      if (!rst && evt_if.evt_valid && evt_if.evt_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got id %0d code %0d, expected no event",
                     evt_if.evt_id, evt_if.evt_code);
         end else begin
            mon_e = exp_q.pop_front();
            check("evt_id", 32'(evt_if.evt_id), 32'(mon_e.id));
            check("evt_code", 32'(evt_if.evt_code), 32'(mon_e.code));
            case (mon_e.code)
               EVT_PRESS: press_cyc[mon_e.id] = cyc;
               EVT_LONG: begin
                  check("long_delay", 32'(cyc - press_cyc[mon_e.id]), 32'(LONG_TICKS * TICK_DIV));
                  rep_cyc[mon_e.id] = cyc;
               end
               EVT_REPEAT: begin
                  check("repeat_gap", 32'(cyc - rep_cyc[mon_e.id]), 32'(REP_TICKS * TICK_DIV));
                  rep_cyc[mon_e.id] = cyc;
               end
               default: ;
            endcase
         end
      end
   end

   initial begin
      rst              = 1'b1;
      btn_n            = '1;
      clr_overflow     = 1'b0;
      evt_if.evt_ready = 1'b1;
      @(negedge clk);
      check("rst_btn_state", 32'(btn_state), 32'd0);
      check("rst_evt_valid", 32'(evt_if.evt_valid), 32'd0);
      check("rst_evt_code", 32'(evt_if.evt_code), 32'd0);
      check("rst_evt_id", 32'(evt_if.evt_id), 32'd0);
      check("rst_overflow", 32'(evt_overflow), 32'd0);
      cycles(2);
      rst = 1'b0;
      cycles(200);
      @(negedge clk);
      check("idle_btn_state", 32'(btn_state), 32'd0);
      check("idle_evt_valid", 32'(evt_if.evt_valid), 32'd0);

      // Two events queued, then reset mid-stream discards them.
      cycles(1);
      evt_if.evt_ready = 1'b0;
      btn_n[3] = 1'b0;
      wait_state(3, 1'b1, 16, "mid_press3");
      cycles(1);
      btn_n[3] = 1'b1;
      wait_state(3, 1'b0, 16, "mid_release3");
      cycles(2);
      @(negedge clk);
      check("mid_valid_before_rst", 32'(evt_if.evt_valid), 32'd1);
      cycles(1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_valid_in_rst", 32'(evt_if.evt_valid), 32'd0);
      cycles(2);
      rst = 1'b0;
      evt_if.evt_ready = 1'b1;
      model_last = N_BTN - 1;
      cycles(20);
      @(negedge clk);
      check("mid_queue_empty", 32'(evt_if.evt_valid), 32'd0);

      // Glitch shorter than the debounce window, then a clean press/release.
      cycles(1);
      btn_n[0] = 1'b0;
      cycles(8);
      btn_n[0] = 1'b1;
      cycles(20);
      @(negedge clk);
      check("glitch_state", 32'(btn_state[0]), 32'd0);
      cycles(1);
      expect_evt(0, EVT_PRESS);
      btn_n[0] = 1'b0;
      wait_state(0, 1'b1, 16, "press0_state");
      cycles(1);
      expect_evt(0, EVT_RELEASE);
      btn_n[0] = 1'b1;
      wait_state(0, 1'b0, 16, "release0_state");
      drain(20, "drain_btn0");

      // Long hold on btn1: PRESS, LONG, ten REPEATs, RELEASE.
      cycles(1);
      expect_evt(1, EVT_PRESS);
      expect_evt(1, EVT_LONG);
      for (int i = 0; i < 10; i++) expect_evt(1, EVT_REPEAT);
      expect_evt(1, EVT_RELEASE);
      btn_n[1] = 1'b0;
      wait_state(1, 1'b1, 16, "long_press_state");
      repeat (60 * TICK_DIV) @(posedge clk);
      #1;
      btn_n[1] = 1'b1;
      wait_state(1, 1'b0, 16, "long_release_state");
      drain(20, "drain_long");

      // Counters restart on the next press: LONG again after 10 ticks.
      cycles(1);
      expect_evt(1, EVT_PRESS);
      expect_evt(1, EVT_LONG);
      expect_evt(1, EVT_RELEASE);
      btn_n[1] = 1'b0;
      wait_state(1, 1'b1, 16, "relong_press_state");
      repeat (11 * TICK_DIV) @(posedge clk);
      #1;
      btn_n[1] = 1'b1;
      wait_state(1, 1'b0, 16, "relong_release_state");
      drain(20, "drain_relong");

      // All four buttons together: round-robin order, nothing lost.
      cycles(1);
      expect_rr(EVT_PRESS);
      btn_n = '0;
      wait_state(0, 1'b1, 16, "arb_press_state");
      check("arb_all_pressed", 32'(btn_state), 32'hF);
      cycles(4);
      expect_rr(EVT_RELEASE);
      btn_n = '1;
      wait_state(0, 1'b0, 16, "arb_release_state");
      drain(20, "drain_arb");
      check("arb_no_overflow", 32'(evt_overflow), 32'd0);

      // Backpressure: 4 in FIFO, 5th pending, 6th RELEASE overwrites it.
      cycles(1);
      evt_if.evt_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         btn_n[2] = 1'b0;
         wait_state(2, 1'b1, 16, "bp_press_state");
         cycles(2);
         btn_n[2] = 1'b1;
         wait_state(2, 1'b0, 16, "bp_release_state");
         cycles(2);
      end
      expect_evt(2, EVT_PRESS);
      expect_evt(2, EVT_RELEASE);
      expect_evt(2, EVT_PRESS);
      expect_evt(2, EVT_RELEASE);
      expect_evt(2, EVT_RELEASE);
      @(negedge clk);
      check("bp_overflow", 32'(evt_overflow), 32'd1);
      check("bp_valid", 32'(evt_if.evt_valid), 32'd1);
      check("bp_head_code", 32'(evt_if.evt_code), 32'(EVT_PRESS));
      check("bp_head_id", 32'(evt_if.evt_id), 32'd2);
      cycles(10);
      @(negedge clk);
      check("bp_head_code_held", 32'(evt_if.evt_code), 32'(EVT_PRESS));
      check("bp_head_id_held", 32'(evt_if.evt_id), 32'd2);
      cycles(1);
      evt_if.evt_ready = 1'b1;
      drain(40, "drain_bp");

      // Overflow clear alone, then clear colliding with a new overflow.
      cycles(1);
      evt_if.evt_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         btn_n[3] = 1'b0;
         wait_state(3, 1'b1, 16, "clr_press3_state");
         cycles(2);
         btn_n[3] = 1'b1;
         wait_state(3, 1'b0, 16, "clr_release3_state");
         cycles(2);
      end
      btn_n[0] = 1'b0;
      wait_state(0, 1'b1, 16, "clr_press0_state");
      cycles(1);
      btn_n[0]     = 1'b1;
      clr_overflow = 1'b1;
      cycles(3);
      @(negedge clk);
      check("ovf_clear_alone", 32'(evt_overflow), 32'd0);
      wait_state(0, 1'b0, 16, "clr_release0_state");
      check("ovf_set_beats_clear", 32'(evt_overflow), 32'd1);
      @(negedge clk);
      check("ovf_cleared_after", 32'(evt_overflow), 32'd0);
      cycles(1);
      clr_overflow = 1'b0;
      expect_evt(3, EVT_PRESS);
      expect_evt(3, EVT_RELEASE);
      expect_evt(3, EVT_PRESS);
      expect_evt(3, EVT_RELEASE);
      expect_evt(0, EVT_RELEASE);
      evt_if.evt_ready = 1'b1;
      drain(40, "drain_clr");
      check("final_overflow", 32'(evt_overflow), 32'd0);
      check("final_valid", 32'(evt_if.evt_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
